multdiv_iter: RTL
=================

MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock is the sole clock, and reset is sampled only on its rising edge.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 data_operandA  input  32  operand A, two's complement (multiplicand / dividend).
REQ-005 data_operandB  input  32  operand B, two's complement (multiplier / divisor).
REQ-006 ctrl_MULT  input  1  single-cycle start pulse for a signed multiply.
REQ-007 ctrl_DIV  input  1  single-cycle start pulse for a signed divide.
REQ-008 data_result  output  32  registered result (product low word or quotient).
REQ-009 data_exception  output  1  registered overflow / divide-by-zero flag, valid with data_result.
REQ-010 data_resultRDY  output  1  registered one-cycle completion pulse.

Function
REQ-011 The block SHALL be a four-state FSM: IDLE, MULT, DIV, DONE.
REQ-012 In IDLE or DONE, ctrl_MULT=1 with ctrl_DIV=0 SHALL latch both operands, clear the 6-bit iteration counter, and move to MULT.
REQ-013 In IDLE or DONE, ctrl_DIV=1 with ctrl_MULT=0 SHALL latch both operands, clear the counter, and move to DIV.
REQ-014 ctrl_MULT=1 and ctrl_DIV=1 in the same cycle SHALL be ignored: no operand latch, next state IDLE.
REQ-015 ctrl_MULT/ctrl_DIV asserted while in MULT or DIV SHALL be ignored; the operation in flight is unaffected.
REQ-016 MULT SHALL perform radix-2 shift-add (Booth or equivalent), one step per cycle, for exactly 32 cycles into a 64-bit signed accumulator.
REQ-017 DIV SHALL perform restoring or non-restoring division, one quotient bit per cycle, for exactly 32 cycles, on operand magnitudes; sign is applied at completion.
REQ-018 After the 32nd iteration the FSM SHALL enter DONE; data_resultRDY SHALL be 1 for exactly the one cycle spent in DONE.
REQ-019 Latency: data_resultRDY SHALL rise 33 rising edges after the edge that sampled the start pulse.
REQ-020 DONE SHALL return to IDLE unless a valid start is sampled, which SHALL begin a new operation with no idle cycle (back-to-back).
REQ-021 Multiply result SHALL be product[31:0].
REQ-022 Multiply exception SHALL be 1 iff product[63:32] is not the sign extension of product[31].
REQ-023 Divide quotient SHALL truncate toward zero.
REQ-024 Divide sign SHALL be negative iff exactly one operand is negative; the remainder is not output.
REQ-025 Divide by zero (B=0) SHALL give data_result=0 and data_exception=1, with full 33-edge latency.
REQ-026 Divide 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-027 data_result and data_exception SHALL update only on the edge entering DONE and SHALL hold until the next entry to DONE or reset.
REQ-028 Operand inputs SHALL be don't-care except in the start cycle.

Reset
REQ-029 reset=1 SHALL force state IDLE, counter 0, accumulators 0, data_result=0, data_exception=0, data_resultRDY=0 on the next rising edge.
REQ-030 Reset SHALL override a simultaneous start pulse.
REQ-031 Reset during MULT/DIV SHALL abort the operation with no data_resultRDY pulse for it.
REQ-032 After reset releases, the first valid start SHALL be accepted in the following cycle.

Verification
REQ-033 MULT 6 x 7 -> data_resultRDY one cycle, 33 edges after start; result 0x0000002A; exception 0.
REQ-034 MULT 0xFFFFFFFB x 3 -> result 0xFFFFFFF1, exception 0; MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-035 DIV 100 / 7 -> 0x0000000E; DIV 0xFFFFFF9C / 7 -> 0xFFFFFFF2; both exception 0.
REQ-036 DIV 5 / 0 -> result 0, exception 1 at edge 33; DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-037 Start MULT, pulse ctrl_DIV at edge 10, pulse reset at edge 20 -> no data_resultRDY; outputs 0; a new MULT 2 x 3 then yields 6.
REQ-038 ctrl_DIV sampled in the DONE cycle of a MULT -> MULT result presented; DIV result pulses data_resultRDY 33 edges later; simultaneous MULT+DIV pulse -> no activity.

Source files
------------

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiplier/divider. Each operation takes 32 one-bit
// steps plus a finalize cycle, and results are presented for one cycle in DONE.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start_mult, start_div;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign start_mult = ctrl_MULT & ~ctrl_DIV;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start_mult) begin
                    state_d  = ST_MULT;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{32{data_operandA[31]}}, data_operandA};
                    mplier_d = data_operandB;
                end else if (start_div) begin
                    state_d = ST_DIV;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = data_operandA[31] ? -data_operandA : data_operandA;
                    dvsr_d  = data_operandB[31] ? -data_operandB : data_operandB;
                    neg_d   = data_operandA[31] ^ data_operandB[31];
                    dz_d    = (data_operandB == '0);
                    ovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == '1);
                end
            end

            ST_MULT: begin
                if (cnt_q == 6'd32) begin
                    state_d  = ST_DONE;
                    rdy_d    = 1'b1;
                    result_d = acc_q[31:0];
                    exc_d    = (acc_q[63:32] != {32{acc_q[31]}});
                end else begin
                    // Bit 31 of a two's complement multiplier carries weight -2^31.
                    if (mplier_q[0])
                        acc_d = (cnt_q == 6'd31) ? acc_q - mcand_q : acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                end
            end

            ST_DIV: begin
                if (cnt_q == 6'd32) begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo_q : quo_q;
                        exc_d    = ovf_q;
                    end
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
